// File: rtl/ucie_ctl_rx_buffer.sv
// RX elastic buffer: captures RDI beats into a circular FIFO and drains them to the FDI.
// Optional macro RX_BUF_OVERFLOW_STICKY_EN makes the overflow flag sticky until reset.
module ucie_ctl_rx_buffer #(
    parameter int unsigned NBYTES = 3,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NBYTES-1:0] i_rdi_pl_data,
    input  logic              i_rdi_pl_valid,
    input  logic              i_buffer_en,
    output logic [NBYTES-1:0] o_fdi_data,
    output logic              o_fdi_data_valid,
    output logic              o_overflow_detected
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [NBYTES-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    logic empty_c;
    logic full_c;
    logic pop_c;
    logic push_acc_c;
    logic ovf_c;

    // Pointer MSB is a wrap bit so full and empty are distinguishable.
    always_comb begin
        empty_c    = (wr_ptr == rd_ptr);
        full_c     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        pop_c      = i_buffer_en && !empty_c;
        push_acc_c = i_rdi_pl_valid && (!full_c || pop_c);
        ovf_c      = i_rdi_pl_valid && full_c && !pop_c;
    end

    always_ff @(posedge i_clk) begin
        if (push_acc_c) begin
            mem[wr_ptr[AW-1:0]] <= i_rdi_pl_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            o_fdi_data          <= '0;
            o_fdi_data_valid    <= 1'b0;
            o_overflow_detected <= 1'b0;
        end else begin
            if (push_acc_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                o_fdi_data <= mem[rd_ptr[AW-1:0]];
                rd_ptr     <= rd_ptr + PW'(1);
            end
            o_fdi_data_valid <= pop_c;
`ifdef RX_BUF_OVERFLOW_STICKY_EN
            if (ovf_c) begin
                o_overflow_detected <= 1'b1;
            end
`else
            o_overflow_detected <= ovf_c;
`endif
        end
    end

endmodule

// File: tb/tb_ucie_ctl_rx_buffer.sv
// Self-checking bench for ucie_ctl_rx_buffer: directed scenarios plus random traffic vs a queue model.
module tb_ucie_ctl_rx_buffer;

    localparam int unsigned NBYTES = 3;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NBYTES-1:0] pl_data;
    logic              pl_valid;
    logic              buf_en;
    logic [NBYTES-1:0] fdi_data;
    logic              fdi_valid;
    logic              ovf;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [NBYTES-1:0] q [$];
    logic [NBYTES-1:0] exp_data  = '0;
    logic              exp_valid = 1'b0;
    logic              exp_ovf   = 1'b0;

    always #5 clk = ~clk;

    ucie_ctl_rx_buffer #(.NBYTES(NBYTES), .DEPTH(DEPTH)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_rdi_pl_data      (pl_data),
        .i_rdi_pl_valid     (pl_valid),
        .i_buffer_en        (buf_en),
        .o_fdi_data         (fdi_data),
        .o_fdi_data_valid   (fdi_valid),
        .o_overflow_detected(ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model across the edge, then compare outputs.
    task automatic step(input logic r, input logic v, input logic [NBYTES-1:0] d, input logic e);
        logic do_pop;
        logic over;
        rst      = r;
        pl_valid = v;
        pl_data  = d;
        buf_en   = e;
        @(posedge clk);
        if (r) begin
            q.delete();
            exp_data  = '0;
            exp_valid = 1'b0;
            exp_ovf   = 1'b0;
        end else begin
            do_pop = e && (q.size() > 0);
            over   = v && (q.size() == DEPTH) && !do_pop;
            exp_valid = do_pop;
            if (do_pop) exp_data = q.pop_front();
            if (v && !over) q.push_back(d);
`ifdef RX_BUF_OVERFLOW_STICKY_EN
            exp_ovf = exp_ovf | over;
`else
            exp_ovf = over;
`endif
        end
        #1;
        check("valid", 32'(fdi_valid), 32'(exp_valid));
        check("data",  32'(fdi_data),  32'(exp_data));
        check("ovf",   32'(ovf),       32'(exp_ovf));
    endtask

    initial begin
        rst = 1'b1; pl_valid = 1'b0; pl_data = '0; buf_en = 1'b0;

        // 1: reset for two edges, then release idle
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // 2: single beat
        step(0, 1, 3'b101, 1);
        step(0, 0, 0, 1);
        check("single_valid", 32'(fdi_valid), 32'd1);
        check("single_data",  32'(fdi_data),  32'h5);
        step(0, 0, 0, 1);

        // 3: streaming, each random beat held two cycles
        for (int i = 0; i < DEPTH; i++) begin
            logic [NBYTES-1:0] b;
            b = NBYTES'($urandom);
            step(0, 1, b, 1);
            step(0, 1, b, 1);
        end
        repeat (3) step(0, 0, 0, 1);

        // 4: fill with en low, then drain
        for (int i = 1; i <= 4; i++) step(0, 1, NBYTES'(i), 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

        // 5: overflow on fifth beat, then drain
        for (int i = 1; i <= 5; i++) step(0, 1, NBYTES'(i), 0);
        check("ovf_raised", 32'(ovf), 32'd1);
        step(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
        step(1, 0, 0, 0);

        // 6: full push+pop, then reset mid-drain
        for (int i = 1; i <= 4; i++) step(0, 1, NBYTES'(i), 0);
        step(0, 1, 3'd7, 1);
        check("fullpp_ovf", 32'(ovf), 32'd0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        check("rst_mid_valid", 32'(fdi_valid), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) != 0),
                 NBYTES'($urandom),
                 ($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
